out_uart_tx: RTL and testbench

Downstream output stage for the RISC CPU. Accepts 8-bit bytes from the CPU's output port (`data_out` plus a write strobe), buffers them in a small FIFO, and serialises each byte onto a UART 8N1 line. This is the first point where CPU results become observable off-chip.

---
 rtl/out_uart_tx.sv | 160 ++++++++++++++++
 tb/tb_out_uart_tx.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/out_uart_tx.sv
// CPU output stage: small byte FIFO feeding a UART 8N1 transmitter.
// Back-to-back frames pop the next byte at the end of STOP with no idle gap.
module out_uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          tx_busy,
  output logic                          tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [AW:0]   L_FULL     = (AW+1)'(FIFO_DEPTH);
  localparam logic [BW-1:0] L_BAUD_END = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          r_busy;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_ovf;

  logic w_baud_end;
  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_baud_end = (r_baud == L_BAUD_END);
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == L_FULL);
  // A pop frees a slot in the same cycle, so a write to a full FIFO is still taken.
  assign w_pop      = !w_empty && ((r_state == IDLE) || ((r_state == STOP) && w_baud_end));
  assign w_push     = wr_en && (!w_full || w_pop);

  assign fifo_full  = w_full;
  assign fifo_count = r_count;
  assign overflow   = r_ovf;
  assign tx_busy    = r_busy;
  assign tx         = r_tx;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (wr_en && w_full && !w_pop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
            r_baud  <= '0;
            r_state <= START;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
          end else begin
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        START: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_state <= DATA;
            r_tx    <= r_shift[0];
          end else begin
            r_baud  <= r_baud + BW'(1);
          end
        end
        DATA: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_state <= STOP;
              r_tx    <= 1'b1;
            end else begin
              // tx is registered, so it takes the bit that lands in shift[0] after this shift.
              r_shift <= r_shift >> 1;
              r_bit   <= r_bit + 3'd1;
              r_tx    <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        STOP: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (w_pop) begin
              r_shift <= r_mem[r_rd_ptr];
              r_state <= START;
              r_tx    <= 1'b0;
            end else begin
              r_state <= IDLE;
              r_tx    <= 1'b1;
              r_busy  <= 1'b0;
            end
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_out_uart_tx.sv
// Bench for out_uart_tx: frame-position reference model checked every cycle,
// plus directed scenarios with hand-computed waveform and decoded-byte checks.
module tb_out_uart_tx;

  localparam int CLKS  = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CLKS;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int HMAX  = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          fifo_full;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic          tx_busy;
  logic          tx;

  out_uart_tx #(.CLKS_PER_BIT(CLKS), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .fifo_full  (fifo_full),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .tx_busy    (tx_busy),
    .tx         (tx)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic tx_hist   [0:HMAX-1];
  logic busy_hist [0:HMAX-1];

  // Reference: byte queue plus "position within current frame".
  logic [7:0] mq [$];
  bit         m_act = 1'b0;
  int         m_pos = 0;
  logic [7:0] m_cur = 8'h00;
  bit         m_ovf = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic exp_tx();
    int b;
    if (!m_act) return 1'b1;
    b = m_pos / CLKS;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_cur[b-1];
  endfunction

  always @(posedge clk) begin
    bit pop;
    bit full;
    cyc++;
    if (rst) begin
      mq.delete();
      m_act = 1'b0;
      m_pos = 0;
      m_ovf = 1'b0;
    end else begin
      pop  = (mq.size() > 0) && (!m_act || (m_pos == FRAME - 1));
      full = (mq.size() == DEPTH);
      if (pop) m_cur = mq.pop_front();
      if (wr_en) begin
        if (!full || pop) mq.push_back(wr_data);
        else m_ovf = 1'b1;
      end
      if (pop) begin
        m_act = 1'b1;
        m_pos = 0;
      end else if (m_act) begin
        if (m_pos == FRAME - 1) m_act = 1'b0;
        else m_pos++;
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      if (cyc < HMAX) begin
        tx_hist[cyc]   = tx;
        busy_hist[cyc] = tx_busy;
      end
      check("tx",         32'(tx),         32'(exp_tx()));
      check("tx_busy",    32'(tx_busy),    32'(m_act));
      check("fifo_count", 32'(fifo_count), 32'(mq.size()));
      check("fifo_full",  32'(fifo_full),  32'(mq.size() == DEPTH));
      check("overflow",   32'(overflow),   32'(m_ovf));
    end
  end

  logic [7:0] dec_q [$];

  task automatic decode(input int from, input int to);
    int i;
    logic [7:0] b;
    dec_q.delete();
    i = from;
    while (i <= to) begin
      if (tx_hist[i] === 1'b0) begin
        for (int k = 0; k < 8; k++) b[k] = tx_hist[i + CLKS*(k+1) + CLKS/2];
        check("stop_bit", 32'(tx_hist[i + 9*CLKS + CLKS/2]), 32'd1);
        dec_q.push_back(b);
        i += FRAME;
      end else begin
        i++;
      end
    end
  endtask

  task automatic write_byte(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int k;
    int run;
    int zeros;
    int exp_bits [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    logic [7:0] exp_b2 [3] = '{8'h01, 8'h80, 8'hFF};
    logic [7:0] exp_b3 [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    logic [7:0] exp_b4 [6] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB5};

    // Reset
    reset_dut();
    repeat (2) @(negedge clk);
    check("rst_tx",    32'(tx),         32'd1);
    check("rst_busy",  32'(tx_busy),    32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_ovf",   32'(overflow),   32'd0);
    check("rst_full",  32'(fifo_full),  32'd0);

    // Single byte 0xA5
    k = cyc + 1;
    write_byte(8'hA5);
    check("t1_count_after_write", 32'(fifo_count), 32'd1);
    repeat (45) @(negedge clk);
    for (int j = 1; j <= 4; j++) check("t1_start_bit", 32'(tx_hist[k+j]), 32'd0);
    for (int b = 0; b < 8; b++)
      for (int h = 0; h < CLKS; h++)
        check("t1_data_bit", 32'(tx_hist[k + 5 + CLKS*b + h]), 32'(exp_bits[b]));
    for (int j = 37; j <= 40; j++) check("t1_stop_bit", 32'(tx_hist[k+j]), 32'd1);
    check("t1_busy_before", 32'(busy_hist[k]),    32'd0);
    check("t1_busy_rise",   32'(busy_hist[k+1]),  32'd1);
    check("t1_busy_last",   32'(busy_hist[k+40]), 32'd1);
    check("t1_busy_fall",   32'(busy_hist[k+41]), 32'd0);
    check("t1_tx_idle",     32'(tx_hist[k+41]),   32'd1);

    // Back-to-back 0x01, 0x80, 0xFF
    k = cyc + 1;
    write_byte(8'h01);
    write_byte(8'h80);
    write_byte(8'hFF);
    repeat (130) @(negedge clk);
    run = 0;
    for (int j = k; j < k + 130; j++) if (busy_hist[j] === 1'b1) run++;
    check("t2_busy_cycles", 32'(run), 32'd120);
    check("t2_busy_first", 32'(busy_hist[k+1]),   32'd1);
    check("t2_busy_last",  32'(busy_hist[k+120]), 32'd1);
    check("t2_busy_fall",  32'(busy_hist[k+121]), 32'd0);
    decode(k, k + 125);
    check("t2_nbytes", 32'(dec_q.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < dec_q.size()) check("t2_byte", 32'(dec_q[i]), 32'(exp_b2[i]));

    // Full / overflow: six writes from idle, sixth dropped
    k = cyc + 1;
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    write_byte(8'h44);
    write_byte(8'h55);
    write_byte(8'h66);
    check("t3_overflow", 32'(overflow),   32'd1);
    check("t3_full",     32'(fifo_full),  32'd1);
    check("t3_count",    32'(fifo_count), 32'd4);
    repeat (210) @(negedge clk);
    check("t3_busy_fall", 32'(busy_hist[k+201]), 32'd0);
    decode(k, k + 212);
    check("t3_nbytes", 32'(dec_q.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < dec_q.size()) check("t3_byte", 32'(dec_q[i]), 32'(exp_b3[i]));

    // Write in the same cycle as the STOP->START pop with the FIFO full
    reset_dut();
    @(negedge clk);
    check("t4_ovf_cleared", 32'(overflow), 32'd0);
    k = cyc + 1;
    write_byte(8'hA0);
    write_byte(8'hA1);
    write_byte(8'hA2);
    write_byte(8'hA3);
    write_byte(8'hA4);
    check("t4_full_before", 32'(fifo_full),  32'd1);
    repeat (36) @(negedge clk);
    check("t4_count_last_stop", 32'(fifo_count), 32'd4);
    check("t4_tx_last_stop",    32'(tx),         32'd1);
    write_byte(8'hB5);
    check("t4_count_same", 32'(fifo_count), 32'd4);
    check("t4_ovf_zero",   32'(overflow),   32'd0);
    check("t4_tx_start",   32'(tx),         32'd0);
    repeat (210) @(negedge clk);
    decode(k, k + 245);
    check("t4_nbytes", 32'(dec_q.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < dec_q.size()) check("t4_byte", 32'(dec_q[i]), 32'(exp_b4[i]));

    // Reset during DATA bit 3 of 0x3C with two bytes queued
    @(negedge clk);
    k = cyc + 1;
    write_byte(8'h3C);
    write_byte(8'h5A);
    write_byte(8'h6B);
    repeat (16) @(negedge clk);
    check("t5_bit3",   32'(tx),         32'd1);
    check("t5_queued", 32'(fifo_count), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_rst_tx",    32'(tx),         32'd1);
    check("t5_rst_busy",  32'(tx_busy),    32'd0);
    check("t5_rst_count", 32'(fifo_count), 32'd0);
    repeat (60) @(negedge clk);
    zeros = 0;
    for (int j = k + 19; j < k + 79; j++)
      if (tx_hist[j] !== 1'b1 || busy_hist[j] !== 1'b0) zeros++;
    check("t5_silent", 32'(zeros), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
